inv_cipher_core: RTL

- Iterative AES inverse cipher datapath and controller; one inverse round per clock.
- Register stage that feeds the existing inv_mix_cols block and consumes its output.
- Per round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns via inv_mix_cols.
- Round keys are read from an external key-schedule store through a combinational address/data port.

---
 rtl/inv_cipher_core_if.sv | 14 +
 rtl/inv_cipher_core.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/inv_cipher_core_if.sv
// rtl/inv_cipher_core_if.sv - control, block and round-key bus of the inverse cipher core
interface inv_cipher_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  // master: requester plus key-schedule store; slave: the cipher core
  modport master (output start, ciphertext, rk_data, input rk_addr, busy, done, plaintext);
  modport slave  (input start, ciphertext, rk_data, output rk_addr, busy, done, plaintext);
endinterface

// File: rtl/inv_cipher_core.sv
// rtl/inv_cipher_core.sv - iterative AES inverse cipher, one inverse round per clock
package aes_gf_pkg;
  // multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // inverse S-box: inverse affine transform followed by field inversion
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction
endpackage

// InvMixColumns over four columns; byte i = bits [127-8i -: 8]
module inv_mix_cols (
  input  logic [127:0] in_i,
  output logic [127:0] out_o
);
  import aes_gf_pkg::*;

  // each column multiplied by the circulant {0e,0b,0d,09}
  always_comb begin
    logic [7:0] s0, s1, s2, s3;
    out_o = '0;
    for (int c = 0; c < 4; c++) begin
      s0 = in_i[127-32*c    -: 8];
      s1 = in_i[127-32*c-8  -: 8];
      s2 = in_i[127-32*c-16 -: 8];
      s3 = in_i[127-32*c-24 -: 8];
      out_o[127-32*c    -: 8] = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
      out_o[127-32*c-8  -: 8] = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
      out_o[127-32*c-16 -: 8] = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
      out_o[127-32*c-24 -: 8] = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
    end
  end
endmodule

module inv_cipher_core #(
  parameter int NR = 10
) (
  input logic         clk,
  input logic         rst,
  inv_cipher_if.slave bus
);
  import aes_gf_pkg::*;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state_q;
  logic [3:0]   round_q;
  logic [127:0] state_reg_q;
  logic [127:0] plaintext_q;
  logic         done_q;

  logic [127:0] isr;
  logic [127:0] ark_d;
  logic [127:0] imc_d;

  // InvShiftRows then InvSubBytes then AddRoundKey on the current state
  always_comb begin
    isr   = '0;
    ark_d = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = state_reg_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      ark_d[127-8*i -: 8] = inv_sbox(isr[127-8*i -: 8]);
    end
    ark_d = ark_d ^ bus.rk_data;
  end

  inv_mix_cols u_imc (
    .in_i  (ark_d),
    .out_o (imc_d)
  );

  // round-key index: last key on accept, round counter while iterating, key 0 last
  always_comb begin
    bus.rk_addr = NR_L;
    case (state_q)
      ROUND:   bus.rk_addr = round_q;
      FINAL:   bus.rk_addr = 4'd0;
      default: bus.rk_addr = NR_L;
    endcase
  end

  // controller and datapath registers; start is only looked at in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      state_reg_q <= '0;
      plaintext_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_reg_q <= bus.ciphertext ^ bus.rk_data;
            round_q     <= NR_L - 4'd1;
            state_q     <= ROUND;
          end
        end
        ROUND: begin
          state_reg_q <= imc_d;
          if (round_q == 4'd1) state_q <= FINAL;
          else                 round_q <= round_q - 4'd1;
        end
        FINAL: begin
          plaintext_q <= ark_d;
          done_q      <= 1'b1;
          round_q     <= 4'd0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.plaintext = plaintext_q;
endmodule
